// File: rtl/bft_switch_cluster_pkg.sv
// Shared definitions for the butterfly-fat-tree switch cluster: port indices,
// mode constants and packet field helpers (packet = {valid, dest, payload}).
package bft_switch_cluster_pkg;

  // Helpers work on packets zero-extended to this width, so p_sz must not exceed it.
  localparam int PKT_MAX_W = 64;
  localparam int DEST_W    = 16;

  localparam int MODE_PI = 0;
  localparam int MODE_T  = 1;

  localparam logic [1:0] P_L  = 2'd0;
  localparam logic [1:0] P_R  = 2'd1;
  localparam logic [1:0] P_UL = 2'd2;
  localparam logic [1:0] P_UR = 2'd3;

  function automatic int up_ports(input int m);
    return (m == MODE_PI) ? 2 : 1;
  endfunction

  function automatic logic pkt_valid(input logic [PKT_MAX_W-1:0] pkt, input int p_sz);
    logic [PKT_MAX_W-1:0] sh;
    sh = pkt >> (p_sz - 1);
    return sh[0];
  endfunction

  function automatic logic [DEST_W-1:0] pkt_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int payload_sz, input int a_w);
    logic [PKT_MAX_W-1:0] sh;
    sh = pkt >> payload_sz;
    return DEST_W'(sh) & ((DEST_W'(1) << a_w) - DEST_W'(1));
  endfunction

endpackage

// File: rtl/bft_switch_cluster_if.sv
// Bus bundle of one switch cluster: child-side l/r buses, parent-side u bus,
// counter clear and per-switch deflection counts.
interface bft_switch_cluster_if #(
  parameter int num_switches = 1,
  parameter int p_sz         = 12,
  parameter int up_n         = 2,
  parameter int cnt_w        = 16
);
  // No valid/ready handshake: every packet carries its own valid bit in its MSB and a
  // packet offered in a cycle is always accepted (bufferless, no backpressure).
  logic [num_switches*p_sz-1:0]      l_bus_i;
  logic [num_switches*p_sz-1:0]      r_bus_i;
  logic [up_n*num_switches*p_sz-1:0] u_bus_i;
  logic [num_switches*p_sz-1:0]      l_bus_o;
  logic [num_switches*p_sz-1:0]      r_bus_o;
  logic [up_n*num_switches*p_sz-1:0] u_bus_o;
  logic                              clr_cnt_i;
  logic [num_switches*cnt_w-1:0]     defl_cnt_o;

  modport master (
    output l_bus_i, r_bus_i, u_bus_i, clr_cnt_i,
    input  l_bus_o, r_bus_o, u_bus_o, defl_cnt_o
  );

  modport slave (
    input  l_bus_i, r_bus_i, u_bus_i, clr_cnt_i,
    output l_bus_o, r_bus_o, u_bus_o, defl_cnt_o
  );
endinterface

// File: rtl/bft_switch_cluster_switch.sv
// One bufferless deflection-routed switch: rotating-priority port allocation,
// registered outputs and a saturating deflection counter.
module bft_switch_cluster_switch
  import bft_switch_cluster_pkg::*;
#(
  parameter int p_sz       = 12,
  parameter int payload_sz = 8,
  parameter int a_w        = 3,
  parameter int level      = 1,
  parameter int addr       = 0,
  parameter int up_n       = 2,
  parameter int cnt_w      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_cnt,
  input  logic [p_sz-1:0]        in_l,
  input  logic [p_sz-1:0]        in_r,
  input  logic [up_n*p_sz-1:0]   in_u,
  output logic [p_sz-1:0]        out_l,
  output logic [p_sz-1:0]        out_r,
  output logic [up_n*p_sz-1:0]   out_u,
  output logic [cnt_w-1:0]       defl_cnt
);

  localparam int n_in   = 2 + up_n;
  localparam int sub_sh = a_w - level;
  localparam int d_sh   = a_w - 1 - level;
  // Ports that physically exist: no parent at the root, no second up port in t mode.
  localparam logic [3:0] avail = {(level != 0) && (up_n == 2), (level != 0), 2'b11};

  logic [p_sz-1:0]   in_pkt [4];
  logic [p_sz-1:0]   nxt    [4];
  logic [p_sz-1:0]   out_q  [4];
  logic [1:0]        ptr_q;
  logic [cnt_w-1:0]  cnt_q;
  logic [cnt_w:0]    cnt_sum;

  logic [3:0]        free;
  logic [2:0]        defl_n;
  logic [p_sz-1:0]   cur;
  logic [DEST_W-1:0] dest;
  logic              go_down;
  logic              got;
  logic [1:0]        want;
  logic [1:0]        sel;
  logic [1:0]        cand;
  logic [1:0]        idx;
  int                idx_sum;

  assign in_pkt[0] = in_l;
  assign in_pkt[1] = in_r;
  assign in_pkt[2] = avail[P_UL] ? in_u[(up_n-1)*p_sz +: p_sz] : '0;

  if (up_n == 2) begin : g_pi
    assign in_pkt[3] = avail[P_UR] ? in_u[0 +: p_sz] : '0;
    assign out_u     = {out_q[2], out_q[3]};
  end else begin : g_t
    assign in_pkt[3] = '0;
    assign out_u     = out_q[2];
  end

  assign out_l    = out_q[0];
  assign out_r    = out_q[1];
  assign defl_cnt = cnt_q;

  // Inputs are visited in rotated priority order; each claims its wanted port if still
  // free, otherwise the first free of UL,UR,L,R. Up-wanting packets use that same order.
  always_comb begin
    free    = avail;
    defl_n  = '0;
    cur     = '0;
    dest    = '0;
    go_down = 1'b0;
    got     = 1'b0;
    want    = P_L;
    sel     = P_L;
    cand    = P_L;
    idx     = '0;
    idx_sum = 0;
    for (int o = 0; o < 4; o++) nxt[o] = '0;
    for (int k = 0; k < n_in; k++) begin
      idx_sum = int'(ptr_q) + k;
      if (idx_sum >= n_in) idx_sum = idx_sum - n_in;
      idx = 2'(idx_sum);
      cur = in_pkt[idx];
      if (pkt_valid(PKT_MAX_W'(cur), p_sz)) begin
        dest    = pkt_dest(PKT_MAX_W'(cur), payload_sz, a_w);
        go_down = (level == 0) || ((dest >> sub_sh) == DEST_W'(addr));
        want    = dest[d_sh] ? P_R : P_L;
        sel     = want;
        got     = go_down && free[want];
        for (int j = 0; j < 4; j++) begin
          cand = 2'(j + 2);
          if (!got && free[cand]) begin
            sel = cand;
            got = 1'b1;
          end
        end
        if (go_down ? (sel != want) : !sel[1]) defl_n = defl_n + 3'd1;
        free[sel] = 1'b0;
        nxt[sel]  = cur;
      end
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + (cnt_w + 1)'(defl_n);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < 4; o++) out_q[o] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int o = 0; o < 4; o++) out_q[o] <= nxt[o];
      ptr_q <= (ptr_q == 2'(n_in - 1)) ? 2'd0 : ptr_q + 2'd1;
      if (clr_cnt) cnt_q <= '0;
      else         cnt_q <= cnt_sum[cnt_w] ? '1 : cnt_sum[cnt_w-1:0];
    end
  end

endmodule

// File: rtl/bft_switch_cluster.sv
// Butterfly-fat-tree switch cluster: slices the child/parent buses into
// num_switches independent channels and instantiates one switch per channel.
module bft_switch_cluster
  import bft_switch_cluster_pkg::*;
#(
  parameter int num_leaves   = 8,
  parameter int payload_sz   = 8,
  parameter int level        = 1,
  parameter int addr         = 0,
  parameter int num_switches = 1,
  parameter int mode         = MODE_PI,
  parameter int cnt_w        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  bft_switch_cluster_if.slave  bus
);

  localparam int a_w  = $clog2(num_leaves);
  localparam int p_sz = 1 + a_w + payload_sz;
  localparam int up_n = up_ports(mode);

  for (genvar i = 0; i < num_switches; i++) begin : g_sw
    logic [up_n*p_sz-1:0] u_in;
    logic [up_n*p_sz-1:0] u_out;

    // pi mode: the ul half of the parent bus sits above the ur half.
    if (up_n == 2) begin : g_pi
      assign u_in = {bus.u_bus_i[(num_switches+i)*p_sz +: p_sz], bus.u_bus_i[i*p_sz +: p_sz]};
      assign bus.u_bus_o[(num_switches+i)*p_sz +: p_sz] = u_out[p_sz +: p_sz];
      assign bus.u_bus_o[i*p_sz +: p_sz]                = u_out[0 +: p_sz];
    end else begin : g_t
      assign u_in = bus.u_bus_i[i*p_sz +: p_sz];
      assign bus.u_bus_o[i*p_sz +: p_sz] = u_out;
    end

    bft_switch_cluster_switch #(
      .p_sz       (p_sz),
      .payload_sz (payload_sz),
      .a_w        (a_w),
      .level      (level),
      .addr       (addr),
      .up_n       (up_n),
      .cnt_w      (cnt_w)
    ) u_switch (
      .clk      (clk),
      .reset    (reset),
      .clr_cnt  (bus.clr_cnt_i),
      .in_l     (bus.l_bus_i[i*p_sz +: p_sz]),
      .in_r     (bus.r_bus_i[i*p_sz +: p_sz]),
      .in_u     (u_in),
      .out_l    (bus.l_bus_o[i*p_sz +: p_sz]),
      .out_r    (bus.r_bus_o[i*p_sz +: p_sz]),
      .out_u    (u_out),
      .defl_cnt (bus.defl_cnt_o[i*cnt_w +: cnt_w])
    );
  end

endmodule

// File: tb/tb_bft_switch_cluster.sv
// Directed bench for bft_switch_cluster: pi (cnt_w=2), t mode, and a 2-switch root
// cluster share one clock; expected outputs are queued per cycle and checked by a monitor.
module tb_bft_switch_cluster;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [49:0]  exp_pi_q [$];
  logic [51:0]  exp_t_q  [$];
  logic [127:0] exp_l0_q [$];
  logic [49:0]  e_pi;
  logic [51:0]  e_t;
  logic [127:0] e_l0;

  always #5 clk = ~clk;

  bft_switch_cluster_if #(.num_switches(1), .p_sz(12), .up_n(2), .cnt_w(2))  bus_pi ();
  bft_switch_cluster_if #(.num_switches(1), .p_sz(12), .up_n(1), .cnt_w(16)) bus_t ();
  bft_switch_cluster_if #(.num_switches(2), .p_sz(12), .up_n(2), .cnt_w(16)) bus_l0 ();

  bft_switch_cluster #(.num_leaves(8), .payload_sz(8), .level(1), .addr(0),
                       .num_switches(1), .mode(0), .cnt_w(2))
    dut_pi (.clk(clk), .reset(reset), .bus(bus_pi.slave));

  bft_switch_cluster #(.num_leaves(8), .payload_sz(8), .level(1), .addr(0),
                       .num_switches(1), .mode(1), .cnt_w(16))
    dut_t (.clk(clk), .reset(reset), .bus(bus_t.slave));

  bft_switch_cluster #(.num_leaves(8), .payload_sz(8), .level(0), .addr(0),
                       .num_switches(2), .mode(0), .cnt_w(16))
    dut_l0 (.clk(clk), .reset(reset), .bus(bus_l0.slave));

  task automatic zero_inputs();
    bus_pi.l_bus_i = '0; bus_pi.r_bus_i = '0; bus_pi.u_bus_i = '0; bus_pi.clr_cnt_i = 1'b0;
    bus_t.l_bus_i  = '0; bus_t.r_bus_i  = '0; bus_t.u_bus_i  = '0; bus_t.clr_cnt_i  = 1'b0;
    bus_l0.l_bus_i = '0; bus_l0.r_bus_i = '0; bus_l0.u_bus_i = '0; bus_l0.clr_cnt_i = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    zero_inputs();
  endtask

  task automatic drive_pi(input logic [11:0] l, input logic [11:0] r, input logic [11:0] ul,
                          input logic [11:0] ur, input logic clr,
                          input logic [11:0] el, input logic [11:0] er, input logic [11:0] eul,
                          input logic [11:0] eur, input logic [1:0] ecnt);
    bus_pi.l_bus_i   = l;
    bus_pi.r_bus_i   = r;
    bus_pi.u_bus_i   = {ul, ur};
    bus_pi.clr_cnt_i = clr;
    exp_pi_q.push_back({el, er, eul, eur, ecnt});
  endtask

  task automatic drive_t(input logic [11:0] l, input logic [11:0] r, input logic [11:0] u,
                         input logic [11:0] el, input logic [11:0] er, input logic [11:0] eu,
                         input logic [15:0] ecnt);
    bus_t.l_bus_i = l;
    bus_t.r_bus_i = r;
    bus_t.u_bus_i = u;
    exp_t_q.push_back({el, er, eu, ecnt});
  endtask

  // Root cluster: parent outputs are always expected to be all-zero.
  task automatic drive_l0(input logic [23:0] l, input logic [23:0] r, input logic [47:0] u,
                          input logic [23:0] el, input logic [23:0] er, input logic [31:0] ecnt);
    bus_l0.l_bus_i = l;
    bus_l0.r_bus_i = r;
    bus_l0.u_bus_i = u;
    exp_l0_q.push_back({el, er, 48'h0, ecnt});
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so compare 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_pi_q.size() != 0) begin
        e_pi = exp_pi_q.pop_front();
        check("pi_l",   128'(bus_pi.l_bus_o),    128'(e_pi[49:38]));
        check("pi_r",   128'(bus_pi.r_bus_o),    128'(e_pi[37:26]));
        check("pi_u",   128'(bus_pi.u_bus_o),    128'(e_pi[25:2]));
        check("pi_cnt", 128'(bus_pi.defl_cnt_o), 128'(e_pi[1:0]));
      end
      if (exp_t_q.size() != 0) begin
        e_t = exp_t_q.pop_front();
        check("t_l",   128'(bus_t.l_bus_o),    128'(e_t[51:40]));
        check("t_r",   128'(bus_t.r_bus_o),    128'(e_t[39:28]));
        check("t_u",   128'(bus_t.u_bus_o),    128'(e_t[27:16]));
        check("t_cnt", 128'(bus_t.defl_cnt_o), 128'(e_t[15:0]));
      end
      if (exp_l0_q.size() != 0) begin
        e_l0 = exp_l0_q.pop_front();
        check("l0_l",   128'(bus_l0.l_bus_o),    128'(e_l0[127:104]));
        check("l0_r",   128'(bus_l0.r_bus_o),    128'(e_l0[103:80]));
        check("l0_u",   128'(bus_l0.u_bus_o),    128'(e_l0[79:32]));
        check("l0_cnt", 128'(bus_l0.defl_cnt_o), 128'(e_l0[31:0]));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    zero_inputs();
    // Reset held with live traffic: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      reset = 1'b1;
      drive_pi(12'hBA5, 12'h822, 12'h803, 12'h804, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 2'd0);
      drive_t(12'hEA5, 12'h811, 12'h833, 12'h0, 12'h0, 12'h0, 16'd0);
      drive_l0(24'hEA5811, 24'h802822, 48'hFFFFFFFFFFFF, 24'h0, 24'h0, 32'h0);
    end

    // p=0 for pi/t/root. pi: dest 3 goes right. t: dest 6 goes up.
    // Root sw0: two left-wanters, r deflects to r; sw1: dest 6 right; u_bus_i ignored.
    tick(); reset = 1'b0;
    drive_pi(12'hBA5, 12'h0, 12'h0, 12'h0, 1'b0, 12'h0, 12'hBA5, 12'h0, 12'h0, 2'd0);
    drive_t(12'hEA5, 12'h0, 12'h0, 12'h0, 12'h0, 12'hEA5, 16'd0);
    drive_l0(24'hEA5811, 24'h000822, 48'hFFFFFFFFFFFF, 24'h000811, 24'hEA5822, 32'h0000_0001);

    // p=1. pi: dest 6 leaves on ul. Root sw1: r wins left, l deflected right.
    tick();
    drive_pi(12'hEA5, 12'h0, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 12'hEA5, 12'h0, 2'd0);
    drive_t(12'hBA5, 12'h0, 12'h0, 12'h0, 12'hBA5, 12'h0, 16'd0);
    drive_l0(24'h801C44, 24'h802BA5, 48'hFFFFFFFFFFFF, 24'h802BA5, 24'h801C44, 32'h0001_0001);

    // pi p=2: parent packets come down on l and r. t p=2: u first takes u, l deflected to l.
    tick();
    drive_pi(12'h0, 12'h0, 12'h8C3, 12'hAB7, 1'b0, 12'h8C3, 12'hAB7, 12'h0, 12'h0, 2'd0);
    drive_t(12'hEA5, 12'h0, 12'hF11, 12'hEA5, 12'h0, 12'hF11, 16'd1);

    // pi p=3: invalid packet ignored. t p=0: three left-wanters, two deflected.
    tick();
    drive_pi(12'h3FF, 12'h0, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 2'd0);
    drive_t(12'h811, 12'h822, 12'h833, 12'h811, 12'h833, 12'h822, 16'd3);

    // pi p=0 then p=1: l/r contention for L, loser deflects to ul.
    tick();
    drive_pi(12'h811, 12'h822, 12'h0, 12'h0, 1'b0, 12'h811, 12'h0, 12'h822, 12'h0, 2'd1);
    tick();
    drive_pi(12'h811, 12'h822, 12'h0, 12'h0, 1'b0, 12'h822, 12'h0, 12'h811, 12'h0, 2'd2);

    // pi p=2: all four want L, three deflect, clear wins.
    tick();
    drive_pi(12'h801, 12'h802, 12'h803, 12'h804, 1'b1, 12'h803, 12'h802, 12'h804, 12'h801, 2'd0);
    // p=3: +3 -> 3; p=0: +3 saturates at 3.
    tick();
    drive_pi(12'h801, 12'h802, 12'h803, 12'h804, 1'b0, 12'h804, 12'h803, 12'h801, 12'h802, 2'd3);
    tick();
    drive_pi(12'h801, 12'h802, 12'h803, 12'h804, 1'b0, 12'h801, 12'h804, 12'h802, 12'h803, 2'd3);

    // p=1: two up-wanters share ul/ur without deflection.
    tick();
    drive_pi(12'hEA5, 12'hF11, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 12'hF11, 12'hEA5, 2'd3);
    // p=2: clear alone.
    tick();
    drive_pi(12'h0, 12'h0, 12'h0, 12'h0, 1'b1, 12'h0, 12'h0, 12'h0, 12'h0, 2'd0);
    // p=3: three up-wanters, the last deflects to l.
    tick();
    drive_pi(12'hEA5, 12'hF11, 12'hC44, 12'h0, 1'b0, 12'hC44, 12'h0, 12'hEA5, 12'hF11, 2'd1);

    // Reset mid-stream discards traffic and counters.
    tick(); reset = 1'b1;
    drive_pi(12'h811, 12'h822, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 2'd0);
    drive_t(12'hEA5, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 16'd0);
    drive_l0(24'hEA5811, 24'h802822, 48'hFFFFFFFFFFFF, 24'h0, 24'h0, 32'h0);

    // Pointer back at 0 after reset: l wins left again.
    tick(); reset = 1'b0;
    drive_pi(12'h811, 12'h822, 12'h0, 12'h0, 1'b0, 12'h811, 12'h0, 12'h822, 12'h0, 2'd1);
    drive_t(12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 16'd0);
    drive_l0(24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 32'h0);

    tick();
    repeat (2) @(negedge clk);
    if (exp_pi_q.size() + exp_t_q.size() + exp_l0_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0",
               exp_pi_q.size() + exp_t_q.size() + exp_l0_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
